load_unit: RTL and testbench
============================

LOAD_UNIT -- requirements
Module: load_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32: memory data and response width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32: byte address width.
REQ-003 SHALL have parameter RESET_VALUE, default 0: reset value of rsp_data.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on posedge clk.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port req_valid, input, 1: load request present.
REQ-007 SHALL have port req_ready, output, 1: unit can accept a request.
REQ-008 SHALL have port req_addr, input, ADDR_WIDTH: byte address of the load.
REQ-009 SHALL have port req_funct3, input, 3: RV32I load type code.
REQ-010 SHALL have port mem_req, output, 1: one-cycle memory read strobe.
REQ-011 SHALL have port mem_addr, output, ADDR_WIDTH: word-aligned read address, req_addr with bits [1:0] forced to 0.
REQ-012 SHALL have port mem_rvalid, input, 1: memory read data valid.
REQ-013 SHALL have port mem_rdata, input, WIDTH: memory read word.
REQ-014 SHALL have port rsp_valid, output, 1: response valid.
REQ-015 SHALL have port rsp_ready, input, 1: consumer accepts the response.
REQ-016 SHALL have port rsp_data, output, WIDTH: extended load result.
REQ-017 SHALL have port rsp_error, output, 1: misaligned or illegal load.

Function
REQ-018 SHALL implement FSM IDLE, REQ, WAIT, RESP; req_ready = (state == IDLE).
REQ-019 SHALL go IDLE->REQ on req_valid && req_ready, registering addr and funct3.
REQ-020 SHALL assert mem_req for exactly one cycle in REQ, with mem_addr driven from the registered address, then go to WAIT.
REQ-021 SHALL sample mem_rvalid only in WAIT; on mem_rvalid, SHALL capture the extended result into rsp_data and go to RESP; SHALL remain in WAIT indefinitely without it.
REQ-022 SHALL hold rsp_valid high and rsp_data/rsp_error stable in RESP until rsp_ready, then go to IDLE; no new request is accepted in that same cycle.
REQ-023 SHALL have minimum latency: accept at cycle t, mem_req at t+1, mem_rvalid at t+2 at the earliest, rsp_valid at t+3.
REQ-024 SHALL decode funct3 as 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-025 SHALL select the byte lane by addr[1:0] and the halfword lane by addr[1].
REQ-026 SHALL sign-extend LB/LH and zero-extend LBU/LHU to WIDTH.
REQ-027 SHALL ignore mem_rvalid outside WAIT, with no state or output change.

Reset
REQ-028 SHALL, on reset, set state to IDLE, mem_req to 0, rsp_valid to 0, rsp_error to 0 and rsp_data to RESET_VALUE.
REQ-029 SHALL abort any in-flight load on reset in any state; a late mem_rvalid after reset SHALL be ignored.

Configuration
REQ-030 SHALL check alignment and legality when macro LOAD_UNIT_MISALIGNED_TRAP_EN is defined: LH/LHU with addr[0]=1, LW with addr[1:0]!=0, or an unlisted funct3 SHALL go REQ-free, IDLE->RESP, with rsp_error=1, rsp_data=0 and no mem_req.
REQ-031 SHALL, without LOAD_UNIT_MISALIGNED_TRAP_EN, tie rsp_error to 0, have LW ignore addr[1:0], treat an unlisted funct3 as LW, and handle misaligned halfwords by addr[1] only.

Structure
REQ-032 SHALL place the funct3 load-code constants and the FSM state enum typedef in shared package load_pkg.
REQ-033 SHALL implement byte/half lane select and extension in combinational sub-module load_extend, instantiated once.

Verification
REQ-034 SHALL cover: LW addr 0x100, mem_rdata 0xDEADBEEF, rvalid 1 cycle after mem_req -> rsp_data 0xDEADBEEF at t+3, mem_addr 0x100.
REQ-035 SHALL cover: LB addr 0x103 and LBU addr 0x103, mem_rdata 0x80FF1234 -> 0xFFFFFF80 and 0x00000080 respectively.
REQ-036 SHALL cover: LH addr 0x102, mem_rdata 0x8001_7FFF, rvalid delayed 5 cycles, rsp_ready held low 3 cycles -> rsp_data 0xFFFF8001 stable throughout and req_ready low until handoff.
REQ-037 SHALL cover: reset asserted in WAIT, then mem_rvalid pulsed -> IDLE, rsp_valid 0, rsp_data RESET_VALUE, no response.
REQ-038 SHALL cover: with the macro, LW addr 0x102 -> no mem_req, rsp_valid with rsp_error=1, rsp_data 0; without the macro, the same load -> mem_addr 0x100, rsp_error 0.

Source files
------------

// File: rtl/load_pkg.sv
// Shared load-unit definitions: RV32I load codes, FSM states and the trap rule.
// The trap rule is only used when LOAD_UNIT_MISALIGNED_TRAP_EN is defined.
package load_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_RESP
    } state_t;

    // A load traps when the access is misaligned for its size or the code is unlisted.
    function automatic logic load_trap(input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic trap;
        case (funct3)
            F3_LB, F3_LBU: trap = 1'b0;
            F3_LH, F3_LHU: trap = addr_lo[0];
            F3_LW:         trap = (addr_lo != 2'b00);
            default:       trap = 1'b1;
        endcase
        return trap;
    endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational byte/halfword lane select and sign/zero extension of a memory word.
module load_extend
    import load_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rdata,
    input  logic [1:0]       addr_lo,
    input  logic [2:0]       funct3,
    output logic [WIDTH-1:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    function automatic logic [WIDTH-1:0] extend_byte(input logic [7:0] b, input logic is_signed);
        return {{(WIDTH-8){is_signed & b[7]}}, b};
    endfunction

    function automatic logic [WIDTH-1:0] extend_half(input logic [15:0] h, input logic is_signed);
        return {{(WIDTH-16){is_signed & h[15]}}, h};
    endfunction

    always_comb begin
        case (addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        case (funct3)
            F3_LB:   data = extend_byte(byte_sel, 1'b1);
            F3_LBU:  data = extend_byte(byte_sel, 1'b0);
            F3_LH:   data = extend_half(half_sel, 1'b1);
            F3_LHU:  data = extend_half(half_sel, 1'b0);
            F3_LW:   data = rdata;
            // Unlisted codes only reach here when trapping is disabled; they load a word.
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/load_unit.sv
// RV32I load unit: one outstanding load, word-aligned memory read, lane extract and extend.
// Define LOAD_UNIT_MISALIGNED_TRAP_EN to report misaligned/illegal loads via rsp_error.
module load_unit
    import load_pkg::*;
#(
    parameter int               WIDTH       = 32,
    parameter int               ADDR_WIDTH  = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [2:0]            req_funct3,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_rvalid,
    input  logic [WIDTH-1:0]      mem_rdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WIDTH-1:0]      rsp_data,
    output logic                  rsp_error
);

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [2:0]            funct3_q;
    logic [WIDTH-1:0]      ext_data;
    logic                  trap;

    assign req_ready = (state == ST_IDLE);
    assign mem_addr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};

`ifdef LOAD_UNIT_MISALIGNED_TRAP_EN
    assign trap = load_trap(req_funct3, req_addr[1:0]);
`else
    assign trap = 1'b0;
`endif

    load_extend #(
        .WIDTH(WIDTH)
    ) u_extend (
        .rdata   (mem_rdata),
        .addr_lo (addr_q[1:0]),
        .funct3  (funct3_q),
        .data    (ext_data)
    );

    // Request fields are plain data: captured on acceptance, never reset.
    always_ff @(posedge clk) begin
        if (req_valid && req_ready) begin
            addr_q   <= req_addr;
            funct3_q <= req_funct3;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            mem_req   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_error <= 1'b0;
            rsp_data  <= RESET_VALUE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        if (trap) begin
                            state     <= ST_RESP;
                            rsp_valid <= 1'b1;
                            rsp_error <= 1'b1;
                            rsp_data  <= '0;
                        end else begin
                            state   <= ST_REQ;
                            mem_req <= 1'b1;
                        end
                    end
                end
                ST_REQ: begin
                    mem_req <= 1'b0;
                    state   <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (mem_rvalid) begin
                        rsp_data  <= ext_data;
                        rsp_error <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    // Handoff returns to IDLE; acceptance of the next load waits a cycle.
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_error <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_unit.sv
// Directed bench for load_unit: responses are checked by a scoreboard monitor.
module tb_load_unit;

    localparam int          WIDTH = 32;
    localparam int          AW    = 32;
    localparam logic [31:0] RV    = 32'hCAFE_F00D;

    logic              clk;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic [AW-1:0]     req_addr;
    logic [2:0]        req_funct3;
    logic              mem_req;
    logic [AW-1:0]     mem_addr;
    logic              mem_rvalid;
    logic [WIDTH-1:0]  mem_rdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [WIDTH-1:0]  rsp_data;
    logic              rsp_error;

    load_unit #(
        .WIDTH       (WIDTH),
        .ADDR_WIDTH  (AW),
        .RESET_VALUE (RV)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_funct3 (req_funct3),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_error  (rsp_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } rsp_t;

    rsp_t sb[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every handoff must match the oldest expected response.
    always @(negedge clk) begin : monitor
        rsp_t e;
        if (!reset && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL unexpected_rsp: got data %h err %b, expected no response", rsp_data, rsp_error);
            end else begin
                e = sb.pop_front();
                check32("rsp_data", rsp_data, e.data);
                check1("rsp_error", rsp_error, e.err);
            end
        end
    end

    task automatic wait_ready();
        int k;
        k = 0;
        while (!req_ready && k < 20) begin
            step();
            k++;
        end
        check1("req_ready_wait", req_ready, 1'b1);
    endtask

    task automatic do_load(input logic [31:0] addr, input logic [2:0] f3, input logic [31:0] rdata,
                           input int delay, input int lag, input logic [31:0] exp_data,
                           input logic exp_err, input logic exp_mem, input logic [31:0] exp_maddr);
        logic [31:0] held;
        wait_ready();
        req_valid  = 1'b1;
        req_addr   = addr;
        req_funct3 = f3;
        sb.push_back('{data: exp_data, err: exp_err});
        step();
        req_valid  = 1'b0;
        @(negedge clk);
        if (exp_mem) begin
            check1("mem_req", mem_req, 1'b1);
            check32("mem_addr", mem_addr, exp_maddr);
            step();
            check1("mem_req_one_cycle", mem_req, 1'b0);
            check1("rsp_early", rsp_valid, 1'b0);
            for (int i = 0; i < delay; i++) begin
                step();
                check1("wait_no_rsp", rsp_valid, 1'b0);
                check1("wait_req_ready", req_ready, 1'b0);
            end
            mem_rvalid = 1'b1;
            mem_rdata  = rdata;
            step();
            mem_rvalid = 1'b0;
            mem_rdata  = 32'h0BAD_0BAD;
        end else begin
            check1("trap_no_mem_req", mem_req, 1'b0);
            check1("trap_rsp_valid", rsp_valid, 1'b1);
            step();
            check1("trap_no_mem_req_later", mem_req, 1'b0);
        end
        check1("rsp_valid", rsp_valid, 1'b1);
        held = rsp_data;
        for (int i = 0; i < lag; i++) begin
            step();
            check1("rsp_hold_valid", rsp_valid, 1'b1);
            check32("rsp_stable", rsp_data, held);
            check1("req_ready_low", req_ready, 1'b0);
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check1("rsp_valid_dropped", rsp_valid, 1'b0);
        check1("req_ready_after", req_ready, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, expected $finish");
        $fatal(1);
    end

    initial begin
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_addr   = '0;
        req_funct3 = 3'b000;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        rsp_ready  = 1'b0;
        repeat (3) step();

        check1("reset_req_ready", req_ready, 1'b1);
        check1("reset_mem_req", mem_req, 1'b0);
        check1("reset_rsp_valid", rsp_valid, 1'b0);
        check1("reset_rsp_error", rsp_error, 1'b0);
        check32("reset_rsp_data", rsp_data, RV);
        reset = 1'b0;
        step();

        // Stray read data while idle must change nothing.
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hFFFF_FFFF;
        step();
        mem_rvalid = 1'b0;
        check1("idle_rvalid_rsp_valid", rsp_valid, 1'b0);
        check32("idle_rvalid_rsp_data", rsp_data, RV);
        check1("idle_rvalid_req_ready", req_ready, 1'b1);

        //       addr          f3      rdata          dly lag exp_data       err   mem   maddr
        do_load(32'h0000_0100, 3'b010, 32'hDEAD_BEEF, 0, 0, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'h0000_0100);
        do_load(32'h0000_0103, 3'b000, 32'h80FF_1234, 0, 0, 32'hFFFF_FF80, 1'b0, 1'b1, 32'h0000_0100);
        do_load(32'h0000_0103, 3'b100, 32'h80FF_1234, 0, 0, 32'h0000_0080, 1'b0, 1'b1, 32'h0000_0100);
        do_load(32'h0000_0102, 3'b001, 32'h8001_7FFF, 5, 3, 32'hFFFF_8001, 1'b0, 1'b1, 32'h0000_0100);
        do_load(32'h0000_0100, 3'b101, 32'h8001_7FFF, 1, 0, 32'h0000_7FFF, 1'b0, 1'b1, 32'h0000_0100);
        do_load(32'h0000_0101, 3'b000, 32'h80FF_1234, 0, 1, 32'h0000_0012, 1'b0, 1'b1, 32'h0000_0100);
        do_load(32'h0000_0202, 3'b000, 32'h80FF_1234, 2, 0, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h0000_0200);
        do_load(32'h0000_0300, 3'b001, 32'h0000_8000, 0, 0, 32'hFFFF_8000, 1'b0, 1'b1, 32'h0000_0300);

`ifdef LOAD_UNIT_MISALIGNED_TRAP_EN
        do_load(32'h0000_0102, 3'b010, 32'h1122_3344, 0, 0, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000);
        do_load(32'h0000_0104, 3'b011, 32'h5566_7788, 0, 2, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000);
        do_load(32'h0000_0101, 3'b001, 32'h0000_F00F, 0, 0, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000);
`else
        do_load(32'h0000_0102, 3'b010, 32'h1122_3344, 0, 0, 32'h1122_3344, 1'b0, 1'b1, 32'h0000_0100);
        do_load(32'h0000_0104, 3'b011, 32'h5566_7788, 1, 0, 32'h5566_7788, 1'b0, 1'b1, 32'h0000_0104);
        do_load(32'h0000_0101, 3'b001, 32'h0000_F00F, 0, 0, 32'hFFFF_F00F, 1'b0, 1'b1, 32'h0000_0100);
`endif

        // Reset while waiting for memory, then a late read return.
        wait_ready();
        req_valid  = 1'b1;
        req_addr   = 32'h0000_0200;
        req_funct3 = 3'b010;
        step();
        req_valid  = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check1("abort_req_ready", req_ready, 1'b1);
        check1("abort_rsp_valid", rsp_valid, 1'b0);
        check1("abort_mem_req", mem_req, 1'b0);
        check32("abort_rsp_data", rsp_data, RV);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1234_5678;
        step();
        mem_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check1("late_rvalid_rsp_valid", rsp_valid, 1'b0);
            check32("late_rvalid_rsp_data", rsp_data, RV);
            check1("late_rvalid_req_ready", req_ready, 1'b1);
            step();
        end

        check32("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
